// File: rtl/vga_img_pkg.sv
// Shared definitions for the VGA image viewer: image geometry, index type
// and the image-select FSM states.
package vga_img_pkg;
  localparam int NUM_IMAGES = 4;
  localparam int IMG_W      = 160;
  localparam int IMG_H      = 120;
  localparam int IMG_PIXELS = IMG_W * IMG_H;

  typedef logic [1:0] img_idx_t;

  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} sel_state_t;

  function automatic img_idx_t next_img(input img_idx_t i);
    return img_idx_t'((int'(i) + 1) % NUM_IMAGES);
  endfunction
endpackage

// File: rtl/image_select_ctrl_switch_debounce.sv
// 2-flop synchroniser followed by a shared-counter debouncer for a vector of
// raw switches; dout only moves after CYCLES unchanged synchronised samples.
module switch_debounce #(
  parameter int WIDTH  = 3,
  parameter int CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic [WIDTH-1:0] sync0_q, sync0_d, sync1_q, sync1_d;
  logic [WIDTH-1:0] prev_q, prev_d, stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    sync0_d  = din;
    sync1_d  = sync0_q;
    prev_d   = sync1_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync1_q != prev_q)    cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    // A saturated count must not let a fresh edge through: require no change this cycle too.
    if (sync1_q == prev_q && cnt_q == CNT_MAX && sync1_q != stable_q)
      stable_d = sync1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_q  <= '0;
      sync1_q  <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync0_q  <= sync0_d;
      sync1_q  <= sync1_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;
endmodule

// File: rtl/image_select_ctrl.sv
// Frame-aligned image selection: debounced switches or a slideshow choose the
// image index, which only changes on a vsync rising into its active level.
module image_select_ctrl
  import vga_img_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 1_000_000,
  parameter int   SLIDE_FRAMES    = 120,
  parameter logic VSYNC_ACTIVE    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw,
  input  logic       auto_en,
  input  logic       vsync,
  output logic [1:0] img_sel,
  output logic       sel_strobe,
  output logic       frame_tick,
  output logic       mode_auto
);
  localparam int FW = $clog2(SLIDE_FRAMES + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(SLIDE_FRAMES - 1);

  logic [2:0] stable;
  img_idx_t   st_sw;
  logic       st_auto;

  switch_debounce #(.WIDTH(3), .CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk   (clk),
    .reset (reset),
    .din   ({auto_en, sw}),
    .dout  (stable)
  );

  assign st_sw   = img_idx_t'(stable[1:0]);
  assign st_auto = stable[2];

  sel_state_t    state_q, state_d;
  img_idx_t      img_q, img_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          strobe_q, strobe_d;
  logic          vsync_q, vsync_d;
  logic          tick;

  // Gated by reset so the pulse is low while held in reset regardless of vsync.
  assign tick = ~reset & (vsync_q != VSYNC_ACTIVE) & (vsync == VSYNC_ACTIVE);

  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    fcnt_d  = fcnt_q;
    vsync_d = vsync;
    if (tick) begin
      if (state_q == MANUAL) begin
        if (st_auto) begin
          state_d = AUTO;
          fcnt_d  = '0;
        end else begin
          img_d = st_sw;
        end
      end else if (!st_auto) begin
        state_d = MANUAL;
        img_d   = st_sw;
      end else if (fcnt_q == FRAME_LAST) begin
        fcnt_d = '0;
        img_d  = next_img(img_q);
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
    strobe_d = (img_d != img_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MANUAL;
      img_q    <= '0;
      fcnt_q   <= '0;
      strobe_q <= 1'b0;
      vsync_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      img_q    <= img_d;
      fcnt_q   <= fcnt_d;
      strobe_q <= strobe_d;
      vsync_q  <= vsync_d;
    end
  end

  assign img_sel    = img_q;
  assign sel_strobe = strobe_q;
  assign frame_tick = tick;
  assign mode_auto  = (state_q == AUTO);
endmodule
